// File: rtl/riscv_hs_staller.sv
// riscv_hs_staller: single-entry rdy/ack pipeline slice that injects burst and
// stall patterns on its output side, so that back-pressure can be exercised
// between any two pipeline stages. Beat order is preserved and no beat is
// ever dropped or duplicated.
//
// Ports:
//   clk          clock, rising edge
//   rstn         asynchronous active-low reset
//   mode         00 pass, 01 pseudo-random, 10 fixed pattern, 11 same as 00
//   rdy_in       upstream valid
//   ack_in       upstream accept (transfer on rdy_in && ack_in)
//   data_in      upstream data
//   rdy_out      downstream valid (transfer on rdy_out && ack_out)
//   ack_out      downstream accept
//   data_out     buffered beat
//   stall_active high while the FSM is in STALL
//   xfer_cnt     number of output transfers, wraps at 2^32
module riscv_hs_staller #(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned BURST_MIN = 0,
  parameter int unsigned BURST_MAX = 3,
  parameter int unsigned STALL_MIN = 1,
  parameter int unsigned STALL_MAX = 5,
  parameter logic [15:0] SEED      = 16'hACE1
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [1:0]       mode,
  input  logic             rdy_in,
  output logic             ack_in,
  input  logic [WIDTH-1:0] data_in,
  output logic             rdy_out,
  input  logic             ack_out,
  output logic [WIDTH-1:0] data_out,
  output logic             stall_active,
  output logic [31:0]      xfer_cnt
);

  localparam int unsigned BRANGE = BURST_MAX - BURST_MIN + 1;
  localparam int unsigned SRANGE = STALL_MAX - STALL_MIN + 1;

  typedef enum logic {RUN, STALL} state_t;

  state_t           r_state;
  logic             r_full;
  logic [WIDTH-1:0] r_data;
  logic [7:0]       r_burst;
  logic [7:0]       r_stall;
  logic [15:0]      r_lfsr;
  logic [31:0]      r_xfer;

  logic       w_in_fire, w_out_fire, w_gen, w_rand;
  logic [7:0] w_draw_b, w_draw_s;

  // Stall generation only runs in modes 01/10; 11 aliases pass-through.
  assign w_gen  = (mode == 2'b01) || (mode == 2'b10);
  assign w_rand = (mode == 2'b01);

  assign rdy_out      = r_full && (r_state == RUN);
  // A full buffer can still take a beat in the cycle it is drained.
  assign ack_in       = !r_full || (rdy_out && ack_out);
  assign w_in_fire    = rdy_in && ack_in;
  assign w_out_fire   = rdy_out && ack_out;
  assign data_out     = r_data;
  assign stall_active = (r_state == STALL);
  assign xfer_cnt     = r_xfer;

  // Low byte picks the burst, high byte the stall; both ranges inclusive.
  assign w_draw_b = w_rand ? 8'(BURST_MIN + (32'(r_lfsr[7:0])  % BRANGE)) : 8'(BURST_MAX);
  assign w_draw_s = w_rand ? 8'(STALL_MIN + (32'(r_lfsr[15:8]) % SRANGE)) : 8'(STALL_MAX);

  // Single-entry buffer and output transfer counter.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_full <= 1'b0;
      r_data <= '0;
      r_xfer <= '0;
    end else begin
      if (w_in_fire) begin
        r_data <= data_in;
        r_full <= 1'b1;
      end else if (w_out_fire) begin
        r_full <= 1'b0;
      end
      if (w_out_fire) r_xfer <= r_xfer + 32'd1;
    end
  end

  // 16-bit Galois LFSR, free-running every cycle out of reset.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_lfsr <= SEED;
    else       r_lfsr <= r_lfsr[0] ? ((r_lfsr >> 1) ^ 16'hB400) : (r_lfsr >> 1);
  end

  // Burst/stall FSM. r_burst counts remaining extra transfers in the burst,
  // r_stall counts remaining stall cycles including the current one.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= RUN;
      r_burst <= 8'(BURST_MAX);
      r_stall <= '0;
    end else begin
      case (r_state)
        RUN: begin
          if (w_out_fire && w_gen) begin
            if (r_burst == 8'd0) begin
              r_state <= STALL;
              r_stall <= w_draw_s;
              r_burst <= w_draw_b;
            end else begin
              r_burst <= r_burst - 8'd1;
            end
          end
        end
        STALL: begin
          if (!w_gen) begin
            // Leaving the stall modes mid-stall restarts a full burst.
            r_state <= RUN;
            r_burst <= 8'(BURST_MAX);
          end else if (r_stall == 8'd1) begin
            r_state <= RUN;
          end else begin
            r_stall <= r_stall - 8'd1;
          end
        end
        default: r_state <= RUN;
      endcase
    end
  end

endmodule

// File: doc/riscv_hs_staller.md
Name: riscv_hs_staller

Overview:
- Parametrised rdy/ack pipeline slice that holds one registered data entry and injects burst/stall patterns on its output side.
- Sits between any two pipeline stages (e.g. id_ex to ex, ex to mem_wb) so verification can exercise back-pressure.
- Supports three modes: pass-through, pseudo-random (synthesizable LFSR) and fixed-pattern.
- Preserves data ordering and never drops or duplicates a beat.

Parameters:
- WIDTH, 32: data width in bits.
- BURST_MIN, 0: minimum extra transfers per burst (a burst is burst_cnt+1 transfers).
- BURST_MAX, 3: maximum extra transfers per burst; must be >= BURST_MIN and <= 255.
- STALL_MIN, 1: minimum stall length in cycles; must be >= 1.
- STALL_MAX, 5: maximum stall length in cycles; must be >= STALL_MIN and <= 255.
- SEED, 16'hACE1: LFSR reset value; must be non-zero.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rstn  input  1  reset, asynchronous assert, active-low.
- mode  input  2  00 pass, 01 random, 10 fixed, 11 treated as 00.
- rdy_in  input  1  upstream data valid.
- ack_in  output  1  upstream accept; a transfer occurs when rdy_in && ack_in.
- data_in  input  WIDTH  upstream data.
- rdy_out  output  1  downstream data valid.
- ack_out  input  1  downstream accept; a transfer occurs when rdy_out && ack_out.
- data_out  output  WIDTH  downstream data (buffer register).
- stall_active  output  1  high while the FSM is in STALL.
- xfer_cnt  output  32  count of output transfers; wraps at 2^32.

Behaviour:
- Reset (rstn low, asynchronous):
  - full=0, data_out=0, rdy_out=0, stall_active=0, xfer_cnt=0.
  - state=RUN, burst_cnt=BURST_MAX, stall_cnt=0, lfsr=SEED.
  - Reset mid-stall or mid-burst discards the buffered beat.
- Buffer (single entry):
  - rdy_out = full && (state==RUN).
  - ack_in = !full || (rdy_out && ack_out), so simultaneous in/out while full is allowed.
  - Input fire loads data_in into data_out and sets full.
  - Output fire without input fire clears full.
  - data_out stays stable while full and not output-fired, including through a stall.
  - Latency is 1 cycle from input fire to rdy_out high, when in RUN.
- LFSR:
  - 16-bit Galois, polynomial mask 16'hB400, shifts every cycle after reset.
  - draw_b = BURST_MIN + (lfsr[7:0] % (BURST_MAX-BURST_MIN+1)); draw_s = STALL_MIN + (lfsr[15:8] % (STALL_MAX-STALL_MIN+1)).
  - Both ranges are inclusive.
- Fixed draws: draw_b = BURST_MAX, draw_s = STALL_MAX.
- FSM, state RUN:
  - On output fire with mode in {01,10}: if burst_cnt==0, go to STALL, load stall_cnt=draw_s and burst_cnt=draw_b (random or fixed per mode); otherwise burst_cnt decrements.
  - Mode 00/11 never leaves RUN; burst_cnt holds.
- FSM, state STALL:
  - rdy_out=0 and stall_active=1.
  - Upstream may still fill an empty buffer.
  - If stall_cnt==1, go to RUN; otherwise stall_cnt decrements. A stall therefore lasts exactly stall_cnt cycles.
  - If mode becomes 00/11 during STALL, go to RUN on the next edge and reload burst_cnt=BURST_MAX.
- Mode changes during RUN take effect at the next burst boundary.
- xfer_cnt increments on every output fire in all modes.

Test Plan:
- Mode 00, rdy_in=1 constant, ack_out=1, data_in = cycle index from 1:
  - Required: after 1-cycle fill latency, rdy_out=1 every cycle.
  - Required: data_out sequence 1,2,3,... with no gaps; xfer_cnt=20 after 20 output cycles.
- Mode 10, defaults, rdy_in=1, ack_out=1:
  - Required: rdy_out repeats 4 high, 5 low; stall_active high exactly during the 5 low cycles.
  - Required: data order preserved; xfer_cnt=8 after two bursts.
- Mode 00, buffer full with 32'hDEADBEEF, ack_out=0 for 6 cycles:
  - Required: rdy_out=1, data_out=32'hDEADBEEF stable, ack_in=0 throughout.
  - Required: on ack_out=1, one transfer; next beat is accepted in the same cycle.
- Mode 01, 1000 output transfers with random ack_out:
  - Required: every burst length is in 1..4 and every stall length is in 1..5.
  - Required: output stream equals input stream (scoreboard); no X on data_out while rdy_out=1.
- Mode 10, assert rstn low for 1 cycle during the 3rd stall cycle:
  - Required: rdy_out=0, xfer_cnt=0, stall_active=0 immediately, asynchronously.
  - Required: after release, first burst is 4 transfers.
- Mode 10, switch mode to 00 during a stall:
  - Required: rdy_out returns high one cycle later and stays high with ack_out=1.
